shift_reg_universal: RTL and testbench

//  Parametrised universal shift register with word framing. Supports hold, shift right,

---
 rtl/shift_reg_universal_pkg.sv | 11 +
 rtl/shift_word_counter.sv | 33 +++
 rtl/shift_reg_universal.sv | 89 ++++++++
 tb/tb_shift_reg_universal.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_universal_pkg.sv
// Shared definitions for the universal shift register: the 2-bit mode encoding.
package shift_reg_universal_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

endpackage

// File: rtl/shift_word_counter.sv
// Counts shifts within the current word; wrap flags the shift that completes a word.
module shift_word_counter #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             shift,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    // The WIDTH-th shift of a word is the one seen while cnt sits at WIDTH-1.
    always_comb begin
        wrap = shift && (cnt == CNT_W'(WIDTH - 1));
    end

    // Shift counter: clear/load restart framing, wrap returns to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || load) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else if (shift) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/shift_reg_universal.sv
// Universal shift register (hold / shift right / shift left / load) with word framing:
// every WIDTH shifts the post-shift contents are latched into word with a one-cycle pulse.
module shift_reg_universal
    import shift_reg_universal_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [1:0]       mode,
    input  logic             si_r,
    input  logic             si_l,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] q,
    output logic             so_r,
    output logic             so_l,
    output logic [CNT_W-1:0] cnt,
    output logic [WIDTH-1:0] word,
    output logic             word_valid
);

    logic [WIDTH-1:0] q_next;
    logic             load;
    logic             shift;
    logic             wrap;

    // Mode mux; clr overrides every mode and suppresses shift/load strobes.
    always_comb begin
        q_next = q;
        load   = 1'b0;
        shift  = 1'b0;
        if (clr) begin
            q_next = '0;
        end else begin
            case (mode_e'(mode))
                MODE_HOLD: q_next = q;
                MODE_SHR: begin
                    q_next = {si_r, q[WIDTH-1:1]};
                    shift  = 1'b1;
                end
                MODE_SHL: begin
                    q_next = {q[WIDTH-2:0], si_l};
                    shift  = 1'b1;
                end
                MODE_LOAD: begin
                    q_next = pin;
                    load   = 1'b1;
                end
                default: q_next = q;
            endcase
        end
    end

    shift_word_counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .load (load),
        .shift(shift),
        .cnt  (cnt),
        .wrap (wrap)
    );

    // Data register and word latch; word captures the post-shift value on wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q          <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            q          <= q_next;
            word_valid <= wrap;
            if (wrap) begin
                word <= q_next;
            end
        end
    end

    // Serial outputs tap the register directly.
    always_comb begin
        so_r = q[0];
        so_l = q[WIDTH-1];
    end

endmodule

// File: tb/tb_shift_reg_universal.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, monitors pop after each edge.
module tb_shift_reg_universal;

    typedef struct packed {
        logic [7:0] q;
        logic [3:0] cnt;
        logic [7:0] word;
        logic       wv;
        logic       so_r;
        logic       so_l;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       clr4 = 1'b0, si_r4 = 1'b0, si_l4 = 1'b0;
    logic [1:0] mode4 = 2'b00;
    logic [3:0] pin4 = '0;
    logic [3:0] q4, word4;
    logic [2:0] cnt4;
    logic       so_r4, so_l4, wv4;

    logic       clr8 = 1'b0, si_r8 = 1'b0, si_l8 = 1'b0;
    logic [1:0] mode8 = 2'b00;
    logic [7:0] pin8 = '0;
    logic [7:0] q8, word8;
    logic [3:0] cnt8;
    logic       so_r8, so_l8, wv8;

    int checks = 0;
    int errors = 0;
    exp_t sb4[$];
    exp_t sb8[$];

    always #5 clk = ~clk;

    shift_reg_universal #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .clr(clr4), .mode(mode4), .si_r(si_r4), .si_l(si_l4),
        .pin(pin4), .q(q4), .so_r(so_r4), .so_l(so_l4), .cnt(cnt4), .word(word4),
        .word_valid(wv4)
    );

    shift_reg_universal #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .clr(clr8), .mode(mode8), .si_r(si_r8), .si_l(si_l8),
        .pin(pin8), .q(q8), .so_r(so_r8), .so_l(so_l8), .cnt(cnt8), .word(word8),
        .word_valid(wv8)
    );

    function automatic exp_t act4();
        exp_t a;
        a = '{q: {4'b0, q4}, cnt: {1'b0, cnt4}, word: {4'b0, word4}, wv: wv4,
              so_r: so_r4, so_l: so_l4};
        return a;
    endfunction

    function automatic exp_t act8();
        exp_t a;
        a = '{q: q8, cnt: cnt8, word: word8, wv: wv8, so_r: so_r8, so_l: so_l8};
        return a;
    endfunction

    // Monitor for the WIDTH=4 instance.
    always @(posedge clk) begin
        #1;
        if (sb4.size() > 0) begin
            exp_t e, a;
            e = sb4.pop_front();
            a = act4();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL w4_step t=%0t got q=%b cnt=%0d word=%b wv=%b so_r=%b so_l=%b want q=%b cnt=%0d word=%b wv=%b so_r=%b so_l=%b",
                         $time, a.q[3:0], a.cnt, a.word[3:0], a.wv, a.so_r, a.so_l,
                         e.q[3:0], e.cnt, e.word[3:0], e.wv, e.so_r, e.so_l);
            end
        end
    end

    // Monitor for the WIDTH=8 instance.
    always @(posedge clk) begin
        #1;
        if (sb8.size() > 0) begin
            exp_t e, a;
            e = sb8.pop_front();
            a = act8();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL w8_step t=%0t got q=%b cnt=%0d word=%b wv=%b want q=%b cnt=%0d word=%b wv=%b",
                         $time, a.q, a.cnt, a.word, a.wv, e.q, e.cnt, e.word, e.wv);
            end
        end
    end

    task automatic step4(input logic c, input logic [1:0] m, input logic sr, input logic sl,
                         input logic [3:0] p, input logic [3:0] eq, input logic [2:0] ec,
                         input logic [3:0] ew, input logic ev);
        exp_t e;
        @(negedge clk);
        rst   = 1'b0;
        clr4  = c;
        mode4 = m;
        si_r4 = sr;
        si_l4 = sl;
        pin4  = p;
        e = '{q: {4'b0, eq}, cnt: {1'b0, ec}, word: {4'b0, ew}, wv: ev,
              so_r: eq[0], so_l: eq[3]};
        sb4.push_back(e);
    endtask

    task automatic step8(input logic [1:0] m, input logic sr, input logic sl,
                         input logic [7:0] eq, input logic [3:0] ec,
                         input logic [7:0] ew, input logic ev);
        exp_t e;
        @(negedge clk);
        rst   = 1'b0;
        clr8  = 1'b0;
        mode8 = m;
        si_r8 = sr;
        si_l8 = sl;
        pin8  = 8'hA5;
        e = '{q: eq, cnt: ec, word: ew, wv: ev, so_r: eq[0], so_l: eq[7]};
        sb8.push_back(e);
    endtask

    task automatic check_reset_now(input string name);
        checks++;
        if (q4 !== '0 || cnt4 !== '0 || word4 !== '0 || wv4 !== 1'b0 ||
            q8 !== '0 || cnt8 !== '0 || word8 !== '0 || wv8 !== 1'b0) begin
            errors++;
            $display("FAIL %s got q4=%b cnt4=%0d word4=%b wv4=%b q8=%b cnt8=%0d word8=%b wv8=%b want all zero",
                     name, q4, cnt4, word4, wv4, q8, cnt8, word8, wv8);
        end
    endtask

    initial begin
        #1;
        check_reset_now("power_on_reset");

        // Leave reset with a hold.
        step4(0, 2'b00, 0, 0, 4'h0, 4'b0000, 0, 4'b0000, 0);

        // Right shifts 1,0,1,1 complete a word.
        step4(0, 2'b01, 1, 0, 4'h0, 4'b1000, 1, 4'b0000, 0);
        step4(0, 2'b01, 0, 1, 4'h0, 4'b0100, 2, 4'b0000, 0);
        step4(0, 2'b01, 1, 0, 4'h0, 4'b1010, 3, 4'b0000, 0);
        step4(0, 2'b01, 1, 0, 4'h0, 4'b1101, 0, 4'b1101, 1);
        step4(0, 2'b00, 0, 0, 4'h0, 4'b1101, 0, 4'b1101, 0);

        // Clear keeps word, then left shifts 1,1,0,0.
        step4(1, 2'b11, 0, 0, 4'hF, 4'b0000, 0, 4'b1101, 0);
        step4(0, 2'b10, 0, 1, 4'h0, 4'b0001, 1, 4'b1101, 0);
        step4(0, 2'b10, 0, 1, 4'h0, 4'b0011, 2, 4'b1101, 0);
        step4(0, 2'b10, 1, 0, 4'h0, 4'b0110, 3, 4'b1101, 0);
        step4(0, 2'b10, 1, 0, 4'h0, 4'b1100, 0, 4'b1100, 1);

        // Parallel load then two right shifts: no pulse.
        step4(0, 2'b11, 1, 1, 4'b1010, 4'b1010, 0, 4'b1100, 0);
        step4(0, 2'b01, 0, 1, 4'h0, 4'b0101, 1, 4'b1100, 0);
        step4(0, 2'b01, 0, 1, 4'h0, 4'b0010, 2, 4'b1100, 0);

        // Clear with shift mode restarts framing; pulse only after 4 more shifts.
        step4(1, 2'b01, 1, 1, 4'h0, 4'b0000, 0, 4'b1100, 0);
        step4(0, 2'b01, 1, 0, 4'h0, 4'b1000, 1, 4'b1100, 0);
        step4(0, 2'b01, 1, 0, 4'h0, 4'b1100, 2, 4'b1100, 0);
        step4(0, 2'b01, 0, 0, 4'h0, 4'b0110, 3, 4'b1100, 0);
        step4(0, 2'b01, 1, 0, 4'h0, 4'b1011, 0, 4'b1011, 1);

        // Mixed directions with holds in the middle of a word.
        step4(0, 2'b01, 1, 0, 4'h0, 4'b1101, 1, 4'b1011, 0);
        step4(0, 2'b01, 0, 0, 4'h0, 4'b0110, 2, 4'b1011, 0);
        step4(0, 2'b00, 1, 1, 4'hF, 4'b0110, 2, 4'b1011, 0);
        step4(0, 2'b00, 0, 1, 4'h3, 4'b0110, 2, 4'b1011, 0);
        step4(0, 2'b00, 1, 0, 4'h9, 4'b0110, 2, 4'b1011, 0);
        step4(0, 2'b10, 0, 1, 4'h0, 4'b1101, 3, 4'b1011, 0);
        step4(0, 2'b10, 1, 0, 4'h0, 4'b1010, 0, 4'b1010, 1);
        step4(0, 2'b00, 0, 0, 4'h0, 4'b1010, 0, 4'b1010, 0);

        // Mid-stream asynchronous reset with inputs active.
        step4(0, 2'b01, 1, 0, 4'h0, 4'b1101, 1, 4'b1010, 0);
        @(negedge clk);
        mode4 = 2'b01; si_r4 = 1'b1; si_l4 = 1'b1; pin4 = 4'hF;
        mode8 = 2'b10; si_r8 = 1'b1; si_l8 = 1'b1;
        #1 rst = 1'b1;
        #1 check_reset_now("async_reset_mid_stream");
        sb4.push_back('{q: 8'h0, cnt: 4'h0, word: 8'h0, wv: 1'b0, so_r: 1'b0, so_l: 1'b0});
        sb8.push_back('{q: 8'h0, cnt: 4'h0, word: 8'h0, wv: 1'b0, so_r: 1'b0, so_l: 1'b0});
        step4(0, 2'b00, 0, 0, 4'h0, 4'b0000, 0, 4'b0000, 0);
        mode8 = 2'b00;

        // WIDTH=8: 3 right, 2 holds, 5 left; pulse on the 8th shift.
        step8(2'b01, 1, 0, 8'b1000_0000, 1, 8'h00, 0);
        step8(2'b01, 1, 0, 8'b1100_0000, 2, 8'h00, 0);
        step8(2'b01, 1, 0, 8'b1110_0000, 3, 8'h00, 0);
        step8(2'b00, 0, 1, 8'b1110_0000, 3, 8'h00, 0);
        step8(2'b00, 1, 1, 8'b1110_0000, 3, 8'h00, 0);
        step8(2'b10, 1, 0, 8'b1100_0000, 4, 8'h00, 0);
        step8(2'b10, 0, 1, 8'b1000_0001, 5, 8'h00, 0);
        step8(2'b10, 1, 0, 8'b0000_0010, 6, 8'h00, 0);
        step8(2'b10, 0, 1, 8'b0000_0101, 7, 8'h00, 0);
        step8(2'b10, 0, 1, 8'b0000_1011, 0, 8'b0000_1011, 1);
        step8(2'b00, 0, 0, 8'b0000_1011, 0, 8'b0000_1011, 0);

        // Drain the scoreboards within a bounded number of cycles.
        begin
            int n;
            n = 0;
            while ((sb4.size() > 0 || sb8.size() > 0) && n < 20) begin
                @(posedge clk);
                n++;
            end
            repeat (2) @(posedge clk);
            if (sb4.size() > 0 || sb8.size() > 0) begin
                errors++;
                $display("FAIL scoreboard_drain got %0d/%0d entries left want 0/0",
                         sb4.size(), sb8.size());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
